// File: rtl/vram_dma_sequencer.sv
// vram_dma_sequencer: one source address + dirty flag per VRAM channel; each VRAM-SYNC programs
// the DMA engine once per dirty channel, lowest channel first. `VRAM_DMA_TIMEOUT_EN adds an IRQ watchdog.
module vram_dma_sequencer #(
  parameter int                NUM_CH         = 3,
  parameter int                ADDR_W         = 32,
  parameter int                CH_BYTES       = 53568,
  parameter logic [ADDR_W-1:0] DST_BASE       = '0,
  parameter logic [31:0]       CTRL_WORD      = 32'h0000_009C,
  parameter int                TIMEOUT_CYCLES = 65535,
  localparam int               CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_wr,
  input  logic [CH_W-1:0]   src_wr_ch,
  input  logic [ADDR_W-1:0] src_wr_data,
  input  logic              vram_sync,
  output logic [2:0]        dma_address,
  output logic              dma_write,
  output logic [31:0]       dma_writedata,
  input  logic              dma_waitrequest,
  input  logic              dma_finish_irq,
  output logic              dma_busy,
  output logic [CH_W-1:0]   cur_ch,
  output logic              xfer_done,
  output logic              dma_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_W_STATUS, S_W_RADDR, S_W_WADDR, S_W_LEN, S_W_CTRL,
    S_WAIT_IRQ, S_W_CLR, S_W_ABORT, S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q [NUM_CH];
  logic [NUM_CH-1:0]   dirty_q, dirty_d, pending_q;
  logic [NUM_CH-1:0]   wr_mask, low_mask, cur_mask;
  logic [CH_W-1:0]     low_ch, cur_ch_q;
  logic [ADDR_W-1:0]   src_lat_q, dst;
  logic                timeout_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    low_ch   = '0;
    low_mask = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_ch      = CH_W'(i);
        low_mask    = '0;
        low_mask[i] = 1'b1;
      end
    end
  end

  // Out-of-range channel numbers never match, so such writes fall away here.
  always_comb begin
    wr_mask  = '0;
    cur_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_mask[i]  = src_wr && (int'(src_wr_ch) == i);
      cur_mask[i] = (int'(cur_ch_q) == i);
    end
  end

  // A CPU write in the same cycle as LOAD re-marks the channel, so the new address is not lost.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == S_LOAD) dirty_d = dirty_d & ~low_mask;
    if (state_q == S_W_ABORT && !dma_waitrequest) dirty_d = dirty_d | cur_mask;
    dirty_d = dirty_d | wr_mask;
  end

  assign dst      = DST_BASE + ADDR_W'(cur_ch_q) * ADDR_W'(CH_BYTES);
  assign dma_busy = (state_q != S_IDLE);
  assign cur_ch   = cur_ch_q;

  always_comb begin
    state_d       = state_q;
    dma_write     = 1'b0;
    dma_address   = 3'd0;
    dma_writedata = 32'd0;
    xfer_done     = 1'b0;
    unique case (state_q)
      S_IDLE:     if (vram_sync && (|dirty_q)) state_d = S_LOAD;
      S_LOAD:     state_d = S_W_STATUS;
      S_W_STATUS: begin
        dma_write = 1'b1;
        if (!dma_waitrequest) state_d = S_W_RADDR;
      end
      S_W_RADDR: begin
        dma_write     = 1'b1;
        dma_address   = 3'd1;
        dma_writedata = 32'(src_lat_q);
        if (!dma_waitrequest) state_d = S_W_WADDR;
      end
      S_W_WADDR: begin
        dma_write     = 1'b1;
        dma_address   = 3'd2;
        dma_writedata = 32'(dst);
        if (!dma_waitrequest) state_d = S_W_LEN;
      end
      S_W_LEN: begin
        dma_write     = 1'b1;
        dma_address   = 3'd3;
        dma_writedata = 32'(CH_BYTES);
        if (!dma_waitrequest) state_d = S_W_CTRL;
      end
      S_W_CTRL: begin
        dma_write     = 1'b1;
        dma_address   = 3'd6;
        dma_writedata = CTRL_WORD;
        if (!dma_waitrequest) state_d = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (dma_finish_irq)   state_d = S_W_CLR;
        else if (timeout_hit) state_d = S_W_ABORT;
      end
      S_W_CLR: begin
        dma_write = 1'b1;
        if (!dma_waitrequest) state_d = S_NEXT;
      end
      S_W_ABORT: begin
        dma_write   = 1'b1;
        dma_address = 3'd6;
        if (!dma_waitrequest) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (|pending_q) state_d = S_LOAD;
        else begin
          xfer_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dirty_q   <= '0;
      pending_q <= '0;
      cur_ch_q  <= '0;
      src_lat_q <= '0;
      // NOTE: the source registers are a handful of flops, not a RAM, so resetting them is cheap and required.
      for (int i = 0; i < NUM_CH; i++) src_q[i] <= '0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_mask[i]) src_q[i] <= src_wr_data;
      end
      if (state_q == S_IDLE && vram_sync && (|dirty_q)) pending_q <= dirty_q;
      else if (state_q == S_LOAD)                       pending_q <= pending_q & ~low_mask;
      if (state_q == S_LOAD) begin
        cur_ch_q  <= low_ch;
        src_lat_q <= src_q[low_ch];
      end
    end
  end

`ifdef VRAM_DMA_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == S_WAIT_IRQ) ? to_cnt_q + 1'b1 : '0;
      if (state_q == S_W_ABORT) err_q <= 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_IRQ.
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign dma_err     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign dma_err     = 1'b0;
`endif

  if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("vram_dma_sequencer: NUM_CH must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

endmodule
